// File: rtl/ram_burst_reader_pkg.sv
// ram_burst_reader_pkg
// Shared definitions for the RAM_32 burst read initiator.
//   state_t           : IDLE / RUN / DRAIN burst sequencer states
//   WORD_BYTES        : byte stride between consecutive 32-bit words
//   DEFAULT_BASE_ADDR : byte address of RAM word 0 in the data segment
package ram_burst_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int          WORD_BYTES        = 4;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

endpackage

// File: rtl/ram_addr_window_check.sv
// ram_addr_window_check
// Combinational validation of a burst request against the RAM window.
// A request is accepted when the start address is word aligned, the word
// count is 1..MEMORY_DEPTH, the start lies at or above BASE_ADDR and the
// burst stays inside the window.
// Build option RAM_BURST_READER_WRAP_EN: the last-word bound is not checked
// because the reader wraps back to BASE_ADDR; only the first word has to
// fall inside the window.
// Ports:
//   start_addr  in  32     first byte address of the burst
//   word_count  in  CNT_W  number of words requested
//   ok          out 1      request is acceptable
module ram_addr_window_check
    import ram_burst_reader_pkg::*;
#(
    parameter int          MEMORY_DEPTH = 32,
    parameter logic [31:0] BASE_ADDR    = DEFAULT_BASE_ADDR,
    parameter int          CNT_W        = $clog2(MEMORY_DEPTH) + 1
) (
    input  logic [31:0]      start_addr,
    input  logic [CNT_W-1:0] word_count,
    output logic             ok
);

    localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(MEMORY_DEPTH);
    // One past the last byte of the window, kept in 33 bits so a window that
    // ends at 2^32 still compares correctly.
    localparam logic [32:0]      WINDOW_END = {1'b0, BASE_ADDR} + 33'(WORD_BYTES * MEMORY_DEPTH);

    logic aligned;
    logic count_ok;
    logic lower_ok;
    logic upper_ok;
`ifndef RAM_BURST_READER_WRAP_EN
    logic [32:0] last_addr;
`endif

    always_comb begin
        aligned  = (start_addr[1:0] == 2'b00);
        count_ok = (word_count != '0) && (word_count <= DEPTH_CNT);
        lower_ok = (start_addr >= BASE_ADDR);
`ifdef RAM_BURST_READER_WRAP_EN
        upper_ok = ({1'b0, start_addr} < WINDOW_END);
`else
        // Address of the final word; a zero count is already rejected, so the
        // underflow of (count - 1) is harmless here.
        last_addr = {1'b0, start_addr} + ((33'(word_count) - 33'd1) << 2);
        upper_ok  = (last_addr < WINDOW_END);
`endif
        ok = aligned && count_ok && lower_ok && upper_ok;
    end

endmodule

// File: rtl/ram_burst_reader.sv
// ram_burst_reader
// Read-side initiator for RAM_32: walks a contiguous range of words starting
// at a byte address and streams them over a valid/ready interface.
// Build option RAM_BURST_READER_WRAP_EN: address wraps from the last RAM word
// back to BASE_ADDR instead of rejecting overflowing ranges.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start_i           request pulse (sampled only in IDLE)
//   start_addr_i      first byte address
//   word_count_i      number of words, 1..MEMORY_DEPTH
//   busy_o            high while a burst is in RUN or DRAIN
//   done_o            one-cycle pulse after the last word is accepted
//   err_o             one-cycle pulse after a rejected request
//   ram_addr_o        byte address to RAM_32.Address_i (registered)
//   ram_write_en_o    RAM_32.Write_en, tied low
//   ram_read_data_i   RAM_32.Read_Data (combinational read)
//   data_o, valid_o   streamed word and its valid
//   ready_i           consumer ready
module ram_burst_reader
    import ram_burst_reader_pkg::*;
#(
    parameter int          DATA_WIDTH   = 32,
    parameter int          MEMORY_DEPTH = 32,
    parameter logic [31:0] BASE_ADDR    = DEFAULT_BASE_ADDR,
    parameter int          CNT_W        = $clog2(MEMORY_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [31:0]           start_addr_i,
    input  logic [CNT_W-1:0]      word_count_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [31:0]           ram_addr_o,
    output logic                  ram_write_en_o,
    input  logic [DATA_WIDTH-1:0] ram_read_data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i
);

`ifdef RAM_BURST_READER_WRAP_EN
    localparam logic [31:0] LAST_WORD_ADDR = BASE_ADDR + 32'(WORD_BYTES * (MEMORY_DEPTH - 1));
`endif

    state_t                state;
    state_t                state_next;
    logic [31:0]           addr;
    logic [31:0]           addr_inc;
    logic [CNT_W-1:0]      remaining;
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  done;
    logic                  err;

    logic                  req_ok;
    logic                  slot_free;
    logic                  load;
    logic                  reject;
    logic                  advance;
    logic                  accept_last;

    ram_addr_window_check #(
        .MEMORY_DEPTH (MEMORY_DEPTH),
        .BASE_ADDR    (BASE_ADDR),
        .CNT_W        (CNT_W)
    ) u_window_check (
        .start_addr (start_addr_i),
        .word_count (word_count_i),
        .ok         (req_ok)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_i && req_ok)          state_next = RUN;
            RUN:     if (slot_free && remaining == CNT_W'(1)) state_next = DRAIN;
            DRAIN:   if (valid && ready_i)           state_next = IDLE;
            default:                                 state_next = IDLE;
        endcase
    end

    // Output and control strobes
    always_comb begin
        // The output slot can take a new word when empty or being drained
        // this cycle; ready_i only feeds registered state through this.
        slot_free      = !valid || ready_i;
        load           = (state == IDLE) && start_i && req_ok;
        reject         = (state == IDLE) && start_i && !req_ok;
        advance        = (state == RUN) && slot_free;
        accept_last    = (state == DRAIN) && valid && ready_i;
        busy_o         = (state != IDLE);
        ram_write_en_o = 1'b0;
`ifdef RAM_BURST_READER_WRAP_EN
        addr_inc = (addr == LAST_WORD_ADDR) ? BASE_ADDR : addr + 32'(WORD_BYTES);
`else
        addr_inc = addr + 32'(WORD_BYTES);
`endif
    end

    // Address, count and output word registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr      <= BASE_ADDR;
            remaining <= '0;
            data      <= '0;
            valid     <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= accept_last;
            err  <= reject;
            if (load) begin
                addr      <= start_addr_i;
                remaining <= word_count_i;
            end else if (advance) begin
                data      <= ram_read_data_i;
                valid     <= 1'b1;
                addr      <= addr_inc;
                remaining <= remaining - CNT_W'(1);
            end else if (accept_last) begin
                valid <= 1'b0;
            end
        end
    end

    assign ram_addr_o = addr;
    assign data_o     = data;
    assign valid_o    = valid;
    assign done_o     = done;
    assign err_o      = err;

endmodule

// File: tb/tb_ram_burst_reader.sv
// tb_ram_burst_reader
// Self-checking bench for ram_burst_reader: a RAM_32 array model answers the
// read address, and expected words are derived from the request (start word
// index plus offset) rather than from the reader's internals.
// Honors RAM_BURST_READER_WRAP_EN for the overflowing-range scenario.
module tb_ram_burst_reader;

    localparam int          DW    = 32;
    localparam int          DEPTH = 32;
    localparam int          CW    = 6;
    localparam logic [31:0] BASE  = 32'h1001_0000;

    logic          clk;
    logic          rst_n;
    logic          start_i;
    logic [31:0]   start_addr_i;
    logic [CW-1:0] word_count_i;
    logic          busy_o;
    logic          done_o;
    logic          err_o;
    logic [31:0]   ram_addr_o;
    logic          ram_write_en_o;
    logic [DW-1:0] ram_read_data_i;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          ready_i;

    ram_burst_reader #(
        .DATA_WIDTH   (DW),
        .MEMORY_DEPTH (DEPTH),
        .BASE_ADDR    (BASE),
        .CNT_W        (CW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_i         (start_i),
        .start_addr_i    (start_addr_i),
        .word_count_i    (word_count_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .err_o           (err_o),
        .ram_addr_o      (ram_addr_o),
        .ram_write_en_o  (ram_write_en_o),
        .ram_read_data_i (ram_read_data_i),
        .data_o          (data_o),
        .valid_o         (valid_o),
        .ready_i         (ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM_32 model: combinational read of the word at the byte address.
    logic [31:0] mem [0:DEPTH-1];
    logic [31:0] ram_off;
    always_comb begin
        ram_off = ram_addr_o - BASE;
        if (ram_addr_o >= BASE && ram_off < 32'(4 * DEPTH))
            ram_read_data_i = mem[ram_off[6:2]];
        else
            ram_read_data_i = 32'hDEAD_BEEF;
    end

    int          n_checks = 0;
    int          n_err    = 0;
    logic [31:0] got_q [$];
    int          done_cnt, done_cyc, first_vld, stall_bad, wen_bad, timed_out;
    logic        busy_c0;
    logic [31:0] addr_c0;

    // Expected word i of a burst starting at byte address start.
    function automatic logic [31:0] exp_word(input logic [31:0] start, input int i);
        int idx;
        idx = int'((start - BASE) >> 2) + i;
`ifdef RAM_BURST_READER_WRAP_EN
        idx = idx % DEPTH;
`endif
        return mem[idx];
    endfunction

    // Issue a request at the current falling edge and act as consumer until
    // done_o is seen or the cycle budget runs out. mode: 0 ready held high,
    // 1 ready pattern 1,0,0,1, 2 random ready. poke_at: cycle at which a
    // second start is pulsed (-1 for none).
    task automatic do_burst(input logic [31:0] a, input int cnt, input int mode, input int poke_at);
        int          budget;
        logic        prev_stall;
        logic [31:0] prev_data;
        got_q.delete();
        done_cnt  = 0;
        done_cyc  = -1;
        first_vld = -1;
        stall_bad = 0;
        wen_bad   = 0;
        timed_out = 1;
        prev_stall = 1'b0;
        prev_data  = '0;
        budget = 8 * cnt + 20;
        start_i      = 1'b1;
        start_addr_i = a;
        word_count_i = CW'(cnt);
        ready_i      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (c == 0) begin
                busy_c0 = busy_o;
                addr_c0 = ram_addr_o;
            end
            if (ram_write_en_o !== 1'b0) wen_bad++;
            if (prev_stall && (valid_o !== 1'b1 || data_o !== prev_data)) stall_bad++;
            if (valid_o === 1'b1 && first_vld < 0) first_vld = c;
            if (done_o === 1'b1) begin
                done_cnt++;
                done_cyc  = c;
                timed_out = 0;
                break;
            end
            case (mode)
                0:       ready_i = 1'b1;
                1:       ready_i = ((c % 4) == 0) || ((c % 4) == 3);
                default: ready_i = 1'($urandom_range(0, 1));
            endcase
            if (c == poke_at) begin
                start_i      = 1'b1;
                start_addr_i = BASE + 32'(4 * 20);
                word_count_i = CW'(3);
            end else begin
                start_i = 1'b0;
            end
            if (valid_o === 1'b1 && ready_i) got_q.push_back(data_o);
            prev_stall = (valid_o === 1'b1) && !ready_i;
            prev_data  = data_o;
            @(posedge clk);
            @(negedge clk);
        end
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        start_i = 1'b0;
        ready_i = 1'b0;
        start_addr_i = '0;
        word_count_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        n_checks++; if (done_o !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done_o); end
        n_checks++; if (err_o !== 1'b0) begin n_err++; $display("FAIL reset_err got=%b exp=0", err_o); end
        n_checks++; if (ram_write_en_o !== 1'b0) begin n_err++; $display("FAIL reset_wen got=%b exp=0", ram_write_en_o); end
        n_checks++; if (data_o !== 32'h0) begin n_err++; $display("FAIL reset_data got=%h exp=0", data_o); end
        n_checks++; if (ram_addr_o !== BASE) begin n_err++; $display("FAIL reset_addr got=%h exp=%h", ram_addr_o, BASE); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] exp4 [4];
        exp4 = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        do_burst(BASE, 4, 0, -1);
        n_checks++; if (timed_out != 0) begin n_err++; $display("FAIL basic_timeout got=%0d exp=0", timed_out); end
        n_checks++; if (addr_c0 !== BASE) begin n_err++; $display("FAIL basic_addr_first got=%h exp=%h", addr_c0, BASE); end
        n_checks++; if (busy_c0 !== 1'b1) begin n_err++; $display("FAIL basic_busy got=%b exp=1", busy_c0); end
        n_checks++; if (first_vld != 1) begin n_err++; $display("FAIL basic_first_valid_cycle got=%0d exp=1", first_vld); end
        n_checks++; if (done_cyc != 5) begin n_err++; $display("FAIL basic_done_cycle got=%0d exp=5", done_cyc); end
        n_checks++; if (got_q.size() != 4) begin n_err++; $display("FAIL basic_count got=%0d exp=4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp4[i]) begin n_err++; $display("FAIL basic_word%0d got=%h exp=%h", i, got_q[i], exp4[i]); end
        end
        n_checks++; if (wen_bad != 0) begin n_err++; $display("FAIL basic_write_en got=%0d cycles high exp=0", wen_bad); end
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (done_o !== 1'b0) begin n_err++; $display("FAIL basic_done_single got=%b exp=0", done_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL basic_busy_after got=%b exp=0", busy_o); end
    endtask

    task automatic test_stall();
        do_burst(BASE, 4, 1, -1);
        n_checks++; if (got_q.size() != 4) begin n_err++; $display("FAIL stall_count got=%0d exp=4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_word(BASE, i)) begin n_err++; $display("FAIL stall_word%0d got=%h exp=%h", i, got_q[i], exp_word(BASE, i)); end
        end
        n_checks++; if (stall_bad != 0) begin n_err++; $display("FAIL stall_hold got=%0d violations exp=0", stall_bad); end
        n_checks++; if (done_cnt != 1) begin n_err++; $display("FAIL stall_done got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_errors();
        logic [31:0] bad_addr [4];
        int          bad_cnt  [4];
        bad_addr = '{BASE + 32'd2, BASE, BASE, BASE - 32'd4};
        bad_cnt  = '{4, 0, 33, 1};
        for (int k = 0; k < 4; k++) begin
            start_i      = 1'b1;
            start_addr_i = bad_addr[k];
            word_count_i = CW'(bad_cnt[k]);
            @(posedge clk);
            @(negedge clk);
            start_i = 1'b0;
            n_checks++; if (err_o !== 1'b1) begin n_err++; $display("FAIL err%0d_pulse got=%b exp=1", k, err_o); end
            n_checks++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL err%0d_busy got=%b exp=0", k, busy_o); end
            @(posedge clk);
            @(negedge clk);
            n_checks++; if (err_o !== 1'b0) begin n_err++; $display("FAIL err%0d_width got=%b exp=0", k, err_o); end
            n_checks++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL err%0d_valid got=%b exp=0", k, valid_o); end
        end
`ifdef RAM_BURST_READER_WRAP_EN
        begin
            int wrap_idx [4];
            wrap_idx = '{30, 31, 0, 1};
            do_burst(32'h1001_0078, 4, 0, -1);
            n_checks++; if (got_q.size() != 4) begin n_err++; $display("FAIL wrap_count got=%0d exp=4", got_q.size()); end
            for (int i = 0; i < 4 && i < got_q.size(); i++) begin
                n_checks++;
                if (got_q[i] !== mem[wrap_idx[i]]) begin n_err++; $display("FAIL wrap_word%0d got=%h exp=%h", i, got_q[i], mem[wrap_idx[i]]); end
            end
        end
`else
        start_i      = 1'b1;
        start_addr_i = 32'h1001_0078;
        word_count_i = CW'(4);
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        n_checks++; if (err_o !== 1'b1) begin n_err++; $display("FAIL overflow_err got=%b exp=1", err_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL overflow_busy got=%b exp=0", busy_o); end
        @(posedge clk);
        @(negedge clk);
`endif
    endtask

    task automatic test_midburst_reset();
        start_i      = 1'b1;
        start_addr_i = BASE;
        word_count_i = CW'(4);
        ready_i      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        n_checks++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL mrst_inflight got=%b exp=1", valid_o); end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL mrst_valid got=%b exp=0", valid_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL mrst_busy got=%b exp=0", busy_o); end
        n_checks++; if (ram_addr_o !== BASE) begin n_err++; $display("FAIL mrst_addr got=%h exp=%h", ram_addr_o, BASE); end
        rst_n = 1'b1;
        do_burst(BASE + 32'd8, 3, 0, -1);
        n_checks++; if (got_q.size() != 3) begin n_err++; $display("FAIL mrst_restart_count got=%0d exp=3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== mem[2 + i]) begin n_err++; $display("FAIL mrst_word%0d got=%h exp=%h", i, got_q[i], mem[2 + i]); end
        end
    endtask

    task automatic test_ignore_start();
        logic [31:0] a;
        a = BASE + 32'(4 * 8);
        do_burst(a, 5, 0, 2);
        n_checks++; if (got_q.size() != 5) begin n_err++; $display("FAIL ignore_count got=%0d exp=5", got_q.size()); end
        for (int i = 0; i < 5 && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== mem[8 + i]) begin n_err++; $display("FAIL ignore_word%0d got=%h exp=%h", i, got_q[i], mem[8 + i]); end
        end
        n_checks++; if (err_o !== 1'b0) begin n_err++; $display("FAIL ignore_err got=%b exp=0", err_o); end
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL ignore_busy_after got=%b exp=0", busy_o); end
    endtask

    task automatic test_back_to_back();
        do_burst(BASE + 32'(4 * 4), 3, 0, -1);
        n_checks++; if (done_cnt != 1) begin n_err++; $display("FAIL b2b_first_done got=%0d exp=1", done_cnt); end
        // Next request issued while done_o is high.
        do_burst(BASE + 32'(4 * 10), 2, 0, -1);
        n_checks++; if (first_vld != 1) begin n_err++; $display("FAIL b2b_first_valid got=%0d exp=1", first_vld); end
        n_checks++; if (got_q.size() != 2) begin n_err++; $display("FAIL b2b_count got=%0d exp=2", got_q.size()); end
        for (int i = 0; i < 2 && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== mem[10 + i]) begin n_err++; $display("FAIL b2b_word%0d got=%h exp=%h", i, got_q[i], mem[10 + i]); end
        end
    endtask

    task automatic test_random();
        int s;
        int cnt;
        logic [31:0] a;
        for (int r = 0; r < 6; r++) begin
            s   = int'($urandom_range(0, DEPTH - 1));
            cnt = int'($urandom_range(1, DEPTH - s));
            a   = BASE + 32'(4 * s);
            do_burst(a, cnt, 2, -1);
            n_checks++; if (got_q.size() != cnt) begin n_err++; $display("FAIL rand%0d_count got=%0d exp=%0d", r, got_q.size(), cnt); end
            for (int i = 0; i < cnt && i < got_q.size(); i++) begin
                n_checks++;
                if (got_q[i] !== exp_word(a, i)) begin n_err++; $display("FAIL rand%0d_word%0d got=%h exp=%h", r, i, got_q[i], exp_word(a, i)); end
            end
            n_checks++; if (stall_bad != 0) begin n_err++; $display("FAIL rand%0d_hold got=%0d exp=0", r, stall_bad); end
            n_checks++; if (done_cnt != 1) begin n_err++; $display("FAIL rand%0d_done got=%0d exp=1", r, done_cnt); end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        mem[0] = 32'h1111_1111;
        mem[1] = 32'h2222_2222;
        mem[2] = 32'h3333_3333;
        mem[3] = 32'h4444_4444;
        rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_stall();
        test_errors();
        test_midburst_reset();
        test_ignore_start();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
